// File: rtl/usb_pkg.sv
// Shared USB host definitions: token/handshake PIDs and the OUT transaction state encoding.
package usb_pkg;
  localparam logic [3:0] PID_OUT = 4'b0001;
  localparam logic [3:0] PID_ACK = 4'b0010;
  localparam logic [3:0] PID_NAK = 4'b1010;

  typedef enum logic [2:0] {IDLE, SEND_TOK, SEND_DAT, WAIT_HS, GAP, DONE} txn_state_t;
endpackage

// File: rtl/usb_gap_timer.sv
// Loadable down-counter with a zero flag; paces the idle gap before a retried token.
module usb_gap_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_L,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/usb_out_txn_ctrl.sv
// Host-side OUT transaction sequencer: token -> DATA -> handshake, with bounded retries.
module usb_out_txn_ctrl
  import usb_pkg::*;
#(
  parameter int MAX_TRIES = 8,
  parameter int GAP_CYC   = 4
) (
  input  logic       clk,
  input  logic       rst_L,
  input  logic       txn_start,
  input  logic [6:0] txn_addr,
  input  logic [3:0] txn_endp,
  output logic       tok_start,
  output logic [3:0] tok_pid,
  output logic [6:0] tok_addr,
  output logic [3:0] tok_endp,
  input  logic       tok_done,
  output logic       dat_start,
  input  logic       dat_done,
  output logic       hs_start,
  input  logic       hs_receive,
  input  logic       hs_ack,
  input  logic       hs_nak,
  input  logic       hs_fail,
  output logic       txn_busy,
  output logic       txn_done,
  output logic       txn_ok,
  output logic       txn_err,
  output logic [3:0] tries_used
);
  localparam int GW = $clog2(GAP_CYC + 1);

  txn_state_t state, state_n;
  logic       entry;      // first cycle spent in the current state
  logic       ok_q;
  logic       hs_good, hs_bad, gap_load, gap_zero;

  always_comb begin
    state_n  = state;
    hs_good  = 1'b0;
    hs_bad   = 1'b0;
    gap_load = 1'b0;
    case (state)
      IDLE:     if (txn_start) state_n = SEND_TOK;
      SEND_TOK: if (tok_done)  state_n = SEND_DAT;
      SEND_DAT: if (dat_done)  state_n = WAIT_HS;
      WAIT_HS: begin
        // a receiver timeout overrides any coincident handshake
        if (hs_fail)         hs_bad = 1'b1;
        else if (hs_receive) begin
          if (hs_ack && !hs_nak) hs_good = 1'b1;
          else                   hs_bad  = 1'b1;
        end
        if (hs_good) state_n = DONE;
        else if (hs_bad) begin
          if (tries_used == 4'(MAX_TRIES)) state_n = DONE;
          else begin
            state_n  = GAP;
            gap_load = 1'b1;
          end
        end
      end
      GAP:      if (gap_zero) state_n = SEND_TOK;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  assign tok_start = (state == SEND_TOK) && entry;
  assign dat_start = (state == SEND_DAT) && entry;
  assign hs_start  = (state == WAIT_HS)  && entry;
  assign tok_pid   = PID_OUT;
  assign txn_busy  = (state != IDLE);
  assign txn_done  = (state == DONE);
  assign txn_ok    = (state == DONE) && ok_q;
  assign txn_err   = (state == DONE) && !ok_q;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state      <= IDLE;
      entry      <= 1'b0;
      ok_q       <= 1'b0;
      tok_addr   <= '0;
      tok_endp   <= '0;
      tries_used <= '0;
    end else begin
      state <= state_n;
      entry <= (state_n != state);
      if (state == IDLE && txn_start) begin
        tok_addr   <= txn_addr;
        tok_endp   <= txn_endp;
        tries_used <= '0;
      end else if (tok_start) begin
        tries_used <= tries_used + 4'd1;
      end
      if (state == WAIT_HS && state_n == DONE) ok_q <= hs_good;
    end
  end

  // Loaded with GAP_CYC-1 so that exactly GAP_CYC cycles are spent in GAP.
  usb_gap_timer #(.W(GW)) u_gap (
    .clk      (clk),
    .rst_L    (rst_L),
    .load     (gap_load),
    .dec      (state == GAP),
    .load_val (GW'(GAP_CYC - 1)),
    .zero     (gap_zero)
  );
endmodule

// File: tb/tb_usb_out_txn_ctrl.sv
// Scoreboard bench for usb_out_txn_ctrl: scripted unit responder, expected results queued per transaction.
module tb_usb_out_txn_ctrl;
  localparam int MAXT = 8;
  localparam int GAPC = 4;

  logic       clk = 1'b0, rst_L = 1'b0;
  logic       txn_start = 1'b0;
  logic [6:0] txn_addr = '0;
  logic [3:0] txn_endp = '0;
  logic       tok_start, dat_start, hs_start;
  logic [3:0] tok_pid, tok_endp, tries_used;
  logic [6:0] tok_addr;
  logic       tok_done = 1'b0, dat_done = 1'b0;
  logic       hs_receive = 1'b0, hs_ack = 1'b0, hs_nak = 1'b0, hs_fail = 1'b0;
  logic       txn_busy, txn_done, txn_ok, txn_err;

  usb_out_txn_ctrl #(.MAX_TRIES(MAXT), .GAP_CYC(GAPC)) dut (
    .clk(clk), .rst_L(rst_L), .txn_start(txn_start), .txn_addr(txn_addr), .txn_endp(txn_endp),
    .tok_start(tok_start), .tok_pid(tok_pid), .tok_addr(tok_addr), .tok_endp(tok_endp),
    .tok_done(tok_done), .dat_start(dat_start), .dat_done(dat_done), .hs_start(hs_start),
    .hs_receive(hs_receive), .hs_ack(hs_ack), .hs_nak(hs_nak), .hs_fail(hs_fail),
    .txn_busy(txn_busy), .txn_done(txn_done), .txn_ok(txn_ok), .txn_err(txn_err),
    .tries_used(tries_used)
  );

  always #5 clk = ~clk;

  // handshake response codes
  localparam int R_ACK = 0, R_NAK = 1, R_FAIL = 2, R_BOTH = 3, R_FAILACK = 4, R_NONE = 5;

  typedef struct {
    logic       ok;
    logic       err;
    logic [3:0] tries;
    logic [6:0] addr;
    logic [3:0] endp;
    int         natt;
  } exp_t;

  exp_t exp_q[$];
  int   hs_q[$];
  int   hs_dly = 0;
  bit   stray = 1'b0;
  int   n_chk = 0, n_pass = 0;
  int   done_cnt = 0, tok_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Unit responder: zero-delay token/data units, scripted handshake receiver.
  initial begin
    bit pend = 1'b0;
    int cnt = 0;
    int code;
    forever begin
      @(posedge clk); #1;
      tok_done = 0; dat_done = 0; hs_receive = 0; hs_ack = 0; hs_nak = 0; hs_fail = 0;
      if (!rst_L) pend = 1'b0;
      else begin
        if (tok_start) tok_done = 1;
        if (dat_start) dat_done = 1;
        if (hs_start) begin pend = 1'b1; cnt = hs_dly; end
        if (pend) begin
          if (cnt == 0) begin
            pend = 1'b0;
            code = (hs_q.size() > 0) ? hs_q.pop_front() : R_ACK;
            case (code)
              R_ACK:     begin hs_receive = 1; hs_ack = 1; end
              R_NAK:     begin hs_receive = 1; hs_nak = 1; end
              R_FAIL:    hs_fail = 1;
              R_BOTH:    begin hs_receive = 1; hs_ack = 1; hs_nak = 1; end
              R_FAILACK: begin hs_fail = 1; hs_receive = 1; hs_ack = 1; end
              default:   hs_receive = 1;
            endcase
          end else begin
            cnt--;
            if (stray) begin tok_done = 1; dat_done = 1; end
          end
        end
      end
    end
  end

  // Monitor: pulse counting, timing checks, scoreboard compare on txn_done.
  initial begin
    int cyc = 0, start_cyc = 0, last_hs = 0;
    int ntok = 0, ndat = 0, nhs = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_L) begin
        ntok = 0; ndat = 0; nhs = 0;
      end else begin
        if (txn_start && !txn_busy) start_cyc = cyc;
        if (hs_receive || hs_fail) last_hs = cyc;
        if (tok_start) begin
          if (ntok == 0) chk("tok_latency", 32'(cyc - start_cyc), 32'd1);
          else           chk("gap_len", 32'(cyc - last_hs), 32'(GAPC + 1));
          ntok++; tok_total++;
        end
        if (dat_start) ndat++;
        if (hs_start)  nhs++;
        if (txn_done) begin
          done_cnt++;
          if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("txn_ok",   32'(txn_ok),     32'(e.ok));
            chk("txn_err",  32'(txn_err),    32'(e.err));
            chk("tries",    32'(tries_used), 32'(e.tries));
            chk("tok_addr", 32'(tok_addr),   32'(e.addr));
            chk("tok_endp", 32'(tok_endp),   32'(e.endp));
            chk("n_tok",    32'(ntok),       32'(e.natt));
            chk("n_dat",    32'(ndat),       32'(e.natt));
            chk("n_hs",     32'(nhs),        32'(e.natt));
            chk("done_lat", 32'(cyc - last_hs), 32'd1);
          end
          ntok = 0; ndat = 0; nhs = 0;
        end
      end
    end
  end

  task automatic run_txn(input logic [6:0] a, input logic [3:0] ep, input int natt, input bit ok);
    exp_t x;
    int   d0;
    x.ok = ok; x.err = !ok; x.tries = 4'(natt); x.addr = a; x.endp = ep; x.natt = natt;
    exp_q.push_back(x);
    d0 = done_cnt;
    @(posedge clk); #1;
    txn_addr = a; txn_endp = ep; txn_start = 1;
    @(posedge clk); #1;
    txn_start = 0;
    for (int i = 0; i < 600 && done_cnt == d0; i++) @(posedge clk);
    chk("done_seen", 32'(done_cnt != d0), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("tries_held", 32'(tries_used), 32'(natt));
    chk("idle_after", 32'(txn_busy), 32'd0);
  endtask

  initial begin
    int t0, d0;
    bit seen;
    #1;
    chk("rst_outs", 32'({txn_busy, tok_start, dat_start, hs_start, txn_done, txn_ok, txn_err}), 32'd0);
    chk("rst_pid",  32'(tok_pid), 32'h1);
    chk("rst_regs", 32'({tries_used, tok_addr, tok_endp}), 32'd0);
    #21 rst_L = 1;

    // 1: happy path
    hs_q = '{R_ACK};
    run_txn(7'h05, 4'h1, 1, 1'b1);

    // 2: NAK, NAK, ACK
    hs_q = '{R_NAK, R_NAK, R_ACK};
    run_txn(7'h12, 4'h3, 3, 1'b1);

    // 3: receiver always times out
    hs_q = '{R_FAIL, R_FAIL, R_FAIL, R_FAIL, R_FAIL, R_FAIL, R_FAIL, R_FAIL, R_ACK};
    t0 = tok_total;
    run_txn(7'h33, 4'h7, MAXT, 1'b0);
    repeat (10) @(posedge clk);
    chk("no_9th_tok", 32'(tok_total - t0), 32'(MAXT));
    hs_q.delete();

    // 4: protocol error, fail+ack collision, empty handshake
    hs_q = '{R_BOTH, R_FAILACK, R_NONE, R_ACK};
    run_txn(7'h40, 4'h6, 4, 1'b1);

    // 5: start while busy ignored; stray done pulses in WAIT_HS ignored
    hs_dly = 4; stray = 1'b1;
    hs_q = '{R_ACK};
    fork
      run_txn(7'h2A, 4'h9, 1, 1'b1);
      begin
        repeat (3) @(posedge clk); #1;
        txn_addr = 7'h7F; txn_endp = 4'hF; txn_start = 1;
        @(posedge clk); #1;
        txn_start = 0;
      end
    join
    stray = 1'b0;

    // 6: reset while waiting for the handshake
    hs_dly = 6;
    hs_q = '{R_ACK};
    d0 = done_cnt;
    @(posedge clk); #1;
    txn_addr = 7'h44; txn_endp = 4'h2; txn_start = 1;
    @(posedge clk); #1;
    txn_start = 0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      seen = hs_start;
    end
    chk("hs_start_seen", 32'(seen), 32'd1);
    @(posedge clk); #3;
    chk("busy_before_rst", 32'(txn_busy), 32'd1);
    rst_L = 0;
    #1;
    chk("async_rst_outs", 32'({txn_busy, tok_start, dat_start, hs_start, txn_done, txn_ok, txn_err}), 32'd0);
    chk("async_rst_regs", 32'({tries_used, tok_addr, tok_endp}), 32'd0);
    #10 rst_L = 1;
    hs_q.delete();
    hs_dly = 0;
    repeat (3) @(posedge clk);
    chk("no_done_on_rst", 32'(done_cnt - d0), 32'd0);
    hs_q = '{R_ACK};
    run_txn(7'h11, 4'h4, 1, 1'b1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
